// File: rtl/ad9914_sweep_seq_if.sv
// Sweep sequencer bus: run control and plan from the host side, command/status to the AD9914 controller.
// master = sequencer, slave = host plus controller (or a bench standing in for them).
interface ad9914_sweep_seq_if;
    logic        start;
    logic        abort;
    logic [31:0] cfg_lower;
    logic [31:0] cfg_upper;
    logic [31:0] cfg_step;
    logic [15:0] cfg_rate;
    logic [15:0] cfg_count;
    logic [23:0] cfg_dwell;
    logic        cfg_bidir;
    logic [31:0] lower_limit;
    logic [31:0] upper_limit;
    logic [31:0] positive_step;
    logic [31:0] negitive_step;
    logic [15:0] positive_rate;
    logic [15:0] negitive_rate;
    logic        sweep_edge;
    logic        update;
    logic        update_config;
    logic        sweep;
    logic        ctrl_busy;
    logic        ctrl_finish;
    logic        dover;
    logic        busy;
    logic        done;
    logic        err_param;
    logic        err_timeout;
    logic [15:0] sweeps_done;

    modport master (
        input  start, abort, cfg_lower, cfg_upper, cfg_step, cfg_rate, cfg_count, cfg_dwell, cfg_bidir,
        input  ctrl_busy, ctrl_finish, dover,
        output lower_limit, upper_limit, positive_step, negitive_step, positive_rate, negitive_rate,
        output sweep_edge, update, update_config, sweep, busy, done, err_param, err_timeout, sweeps_done
    );

    modport slave (
        output start, abort, cfg_lower, cfg_upper, cfg_step, cfg_rate, cfg_count, cfg_dwell, cfg_bidir,
        output ctrl_busy, ctrl_finish, dover,
        input  lower_limit, upper_limit, positive_step, negitive_step, positive_rate, negitive_rate,
        input  sweep_edge, update, update_config, sweep, busy, done, err_param, err_timeout, sweeps_done
    );
endinterface

// File: rtl/ad9914_sweep_seq.sv
// AD9914 sweep sequencer: issues update/update_config/sweep one at a time, counts dover edges,
// dwells between sweeps and stops on count, abort or timeout. Command pulses are registered.
module ad9914_sweep_seq #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000
) (
    input logic               clk,
    input logic               rst,
    ad9914_sweep_seq_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CFG, S_ARM, S_RUN, S_DWELL, S_STOP, S_FIN} state_t;
    typedef enum logic [1:0] {PH_ISSUE, PH_ACK, PH_DONE} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic        upd_q, upd_d, cfgu_q, cfgu_d, swp_q, swp_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        errp_q, errp_d, errt_q, errt_d;
    logic [15:0] sweeps_q, sweeps_d;
    logic        edge_q, edge_d, abort_q, abort_d;
    logic [31:0] lower_q, lower_d, upper_q, upper_d, step_q, step_d;
    logic [15:0] rate_q, rate_d, count_q, count_d;
    logic [23:0] dwell_q, dwell_d, dwell_cnt_q, dwell_cnt_d;
    logic        bidir_q, bidir_d;
    logic [31:0] tmo_q, tmo_d;
    logic        sync1_q, sync2_q, sync3_q;

    logic        dover_rise, tmo_exp, tmo_fire, abortable, abort_any, edge_next;
    logic [15:0] sweeps_inc;

    assign dover_rise = sync2_q & ~sync3_q;
    assign tmo_exp    = (tmo_q >= TIMEOUT_CYCLES - 32'd1);
    assign abortable  = (state_q == S_LOAD) || (state_q == S_CFG) || (state_q == S_ARM);
    assign abort_any  = abortable & (bus.abort | abort_q);
    assign edge_next  = bidir_q ? ~edge_q : edge_q;
    assign sweeps_inc = (sweeps_q == 16'hFFFF) ? sweeps_q : sweeps_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        upd_d       = 1'b0;
        cfgu_d      = 1'b0;
        swp_d       = 1'b0;
        done_d      = 1'b0;
        busy_d      = busy_q;
        errp_d      = errp_q;
        errt_d      = errt_q;
        sweeps_d    = sweeps_q;
        edge_d      = edge_q;
        abort_d     = abort_q;
        lower_d     = lower_q;
        upper_d     = upper_q;
        step_d      = step_q;
        rate_d      = rate_q;
        count_d     = count_q;
        dwell_d     = dwell_q;
        bidir_d     = bidir_q;
        dwell_cnt_d = dwell_cnt_q;
        tmo_d       = tmo_q + 32'd1;
        tmo_fire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    errp_d = 1'b0;
                    errt_d = 1'b0;
                    if (bus.cfg_lower >= bus.cfg_upper || bus.cfg_step == 32'd0) begin
                        errp_d = 1'b1;
                    end else begin
                        lower_d  = bus.cfg_lower;
                        upper_d  = bus.cfg_upper;
                        step_d   = bus.cfg_step;
                        rate_d   = bus.cfg_rate;
                        count_d  = bus.cfg_count;
                        dwell_d  = bus.cfg_dwell;
                        bidir_d  = bus.cfg_bidir;
                        busy_d   = 1'b1;
                        edge_d   = 1'b1;
                        sweeps_d = 16'd0;
                        abort_d  = 1'b0;
                        state_d  = S_LOAD;
                        phase_d  = PH_ISSUE;
                    end
                end
            end
            S_LOAD, S_CFG, S_ARM, S_STOP, S_FIN: begin
                if (abortable && bus.abort) abort_d = 1'b1;
                case (phase_q)
                    PH_ISSUE: begin
                        // An abort before the pulse leaves nothing outstanding, so go straight to disarm.
                        if (abort_any) begin
                            state_d = S_STOP;
                        end else if (bus.ctrl_finish && !bus.ctrl_busy) begin
                            phase_d = PH_ACK;
                            case (state_q)
                                S_LOAD:  upd_d  = 1'b1;
                                S_ARM:   swp_d  = 1'b1;
                                default: cfgu_d = 1'b1;
                            endcase
                        end
                    end
                    PH_ACK: begin
                        if (bus.ctrl_busy) phase_d = PH_DONE;
                        else               tmo_fire = tmo_exp;
                    end
                    default: begin
                        if (bus.ctrl_finish) begin
                            phase_d = PH_ISSUE;
                            if (abort_any) begin
                                state_d = S_STOP;
                            end else begin
                                case (state_q)
                                    S_LOAD: state_d = S_CFG;
                                    S_CFG:  state_d = S_ARM;
                                    S_ARM:  state_d = S_RUN;
                                    S_FIN: begin
                                        done_d  = 1'b1;
                                        busy_d  = 1'b0;
                                        state_d = S_IDLE;
                                    end
                                    default: begin
                                        busy_d  = 1'b0;
                                        state_d = S_IDLE;
                                    end
                                endcase
                            end
                        end else begin
                            tmo_fire = tmo_exp;
                        end
                    end
                endcase
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_STOP;
                    phase_d = PH_ISSUE;
                end else if (dover_rise) begin
                    sweeps_d = sweeps_inc;
                    if (count_q != 16'd0 && sweeps_inc == count_q) begin
                        state_d = S_FIN;
                    end else if (dwell_q == 24'd0) begin
                        state_d = S_CFG;
                        edge_d  = edge_next;
                    end else begin
                        state_d     = S_DWELL;
                        dwell_cnt_d = 24'd0;
                    end
                end else begin
                    tmo_fire = tmo_exp;
                end
            end
            S_DWELL: begin
                if (bus.abort) begin
                    state_d = S_STOP;
                end else if (dwell_cnt_q == dwell_q - 24'd1) begin
                    state_d = S_CFG;
                    edge_d  = edge_next;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 24'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_fire) begin
            errt_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
            phase_d = PH_ISSUE;
        end
        if (state_d != state_q || phase_d != phase_q) tmo_d = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_ISSUE;
            upd_q       <= 1'b0;
            cfgu_q      <= 1'b0;
            swp_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            errp_q      <= 1'b0;
            errt_q      <= 1'b0;
            sweeps_q    <= 16'd0;
            edge_q      <= 1'b1;
            abort_q     <= 1'b0;
            lower_q     <= 32'd0;
            upper_q     <= 32'd0;
            step_q      <= 32'd0;
            rate_q      <= 16'd0;
            count_q     <= 16'd0;
            dwell_q     <= 24'd0;
            bidir_q     <= 1'b0;
            dwell_cnt_q <= 24'd0;
            tmo_q       <= 32'd0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            upd_q       <= upd_d;
            cfgu_q      <= cfgu_d;
            swp_q       <= swp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            errp_q      <= errp_d;
            errt_q      <= errt_d;
            sweeps_q    <= sweeps_d;
            edge_q      <= edge_d;
            abort_q     <= abort_d;
            lower_q     <= lower_d;
            upper_q     <= upper_d;
            step_q      <= step_d;
            rate_q      <= rate_d;
            count_q     <= count_d;
            dwell_q     <= dwell_d;
            bidir_q     <= bidir_d;
            dwell_cnt_q <= dwell_cnt_d;
            tmo_q       <= tmo_d;
            sync1_q     <= bus.dover;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
        end
    end

    assign bus.lower_limit   = lower_q;
    assign bus.upper_limit   = upper_q;
    assign bus.positive_step = step_q;
    assign bus.negitive_step = step_q;
    assign bus.positive_rate = rate_q;
    assign bus.negitive_rate = rate_q;
    assign bus.sweep_edge    = edge_q;
    assign bus.update        = upd_q;
    assign bus.update_config = cfgu_q;
    assign bus.sweep         = swp_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err_param     = errp_q;
    assign bus.err_timeout   = errt_q;
    assign bus.sweeps_done   = sweeps_q;
endmodule

// File: tb/tb_ad9914_sweep_seq.sv
// Bench for ad9914_sweep_seq: two instances (default and 50-cycle timeout) each driven by a small
// controller model that logs commands (1=update, 10+edge=update_config, 3=sweep).
module tb_ad9914_sweep_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errs = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ad9914_sweep_seq_if bus_a ();
    ad9914_sweep_seq_if bus_b ();

    ad9914_sweep_seq dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ad9914_sweep_seq #(.TIMEOUT_CYCLES(32'd50)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int log_a[$];
    int log_b[$];
    int a_cnt, a_dt, a_dh, b_cnt;
    int a_proto = 0;
    int b_proto = 0;
    int done_a = 0;

    function automatic int cmd_code(input logic u, input logic c, input logic e);
        if (u) return 1;
        if (c) return 10 + int'(e);
        return 3;
    endfunction

    // Controller A: 2-cycle busy per command, dover pulse 100 cycles after sweep, disarm on update_config.
    always @(posedge clk) begin
        if (!rst) begin
            bus_a.ctrl_busy <= 1'b0; bus_a.ctrl_finish <= 1'b1; bus_a.dover <= 1'b0;
            a_cnt <= 0; a_dt <= 0; a_dh <= 0;
        end else begin
            if (a_dt != 0) begin
                a_dt <= a_dt - 1;
                if (a_dt == 1) begin bus_a.dover <= 1'b1; a_dh <= 4; end
            end
            if (a_dh != 0) begin
                a_dh <= a_dh - 1;
                if (a_dh == 1) bus_a.dover <= 1'b0;
            end
            if (bus_a.update || bus_a.update_config || bus_a.sweep) begin
                if (bus_a.ctrl_busy || !bus_a.ctrl_finish || (int'(bus_a.update) + int'(bus_a.update_config) + int'(bus_a.sweep)) != 1)
                    a_proto <= a_proto + 1;
                bus_a.ctrl_busy <= 1'b1; bus_a.ctrl_finish <= 1'b0; a_cnt <= 2;
                log_a.push_back(cmd_code(bus_a.update, bus_a.update_config, bus_a.sweep_edge));
                if (bus_a.sweep) a_dt <= 100;
                if (bus_a.update_config) a_dt <= 0;
            end else if (bus_a.ctrl_busy) begin
                if (a_cnt == 1) begin bus_a.ctrl_busy <= 1'b0; bus_a.ctrl_finish <= 1'b1; end
                a_cnt <= a_cnt - 1;
            end
        end
    end

    // Controller B: same handshake, dover never rises.
    always @(posedge clk) begin
        if (!rst) begin
            bus_b.ctrl_busy <= 1'b0; bus_b.ctrl_finish <= 1'b1; bus_b.dover <= 1'b0; b_cnt <= 0;
        end else if (bus_b.update || bus_b.update_config || bus_b.sweep) begin
            if (bus_b.ctrl_busy || !bus_b.ctrl_finish) b_proto <= b_proto + 1;
            bus_b.ctrl_busy <= 1'b1; bus_b.ctrl_finish <= 1'b0; b_cnt <= 2;
            log_b.push_back(cmd_code(bus_b.update, bus_b.update_config, bus_b.sweep_edge));
        end else if (bus_b.ctrl_busy) begin
            if (b_cnt == 1) begin bus_b.ctrl_busy <= 1'b0; bus_b.ctrl_finish <= 1'b1; end
            b_cnt <= b_cnt - 1;
        end
    end

    always @(posedge clk) if (bus_a.done) done_a <= done_a + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag, input int got[$], input int exp[$]);
        check_eq({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check_eq($sformatf("%s_%0d", tag, i), got[i], exp[i]);
    endtask

    task automatic plan_a(input logic [31:0] lo, input logic [31:0] up, input logic [31:0] st,
                          input logic [15:0] cnt, input logic [23:0] dw, input logic bd);
        bus_a.cfg_lower = lo; bus_a.cfg_upper = up; bus_a.cfg_step = st; bus_a.cfg_rate = 16'd1;
        bus_a.cfg_count = cnt; bus_a.cfg_dwell = dw; bus_a.cfg_bidir = bd;
    endtask

    task automatic start_a();
        @(negedge clk) bus_a.start = 1'b1;
        @(negedge clk) bus_a.start = 1'b0;
    endtask

    task automatic abort_a();
        @(negedge clk) bus_a.abort = 1'b1;
        @(negedge clk) bus_a.abort = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget, input string tag);
        int n = 0;
        while (bus_a.busy && n < budget) begin @(negedge clk); n++; end
        check_eq({tag, "_idle_to"}, bus_a.busy, 1'b0);
        @(negedge clk);
    endtask

    int d0, t1, t2, n, busy_or;

    initial begin
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        plan_a(32'd0, 32'd0, 32'd0, 16'd0, 24'd0, 1'b0);
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.cfg_lower = 32'd100; bus_b.cfg_upper = 32'd200;
        bus_b.cfg_step = 32'd1; bus_b.cfg_rate = 16'd1; bus_b.cfg_count = 16'd1; bus_b.cfg_dwell = 24'd0; bus_b.cfg_bidir = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", bus_a.busy, 1'b0);
        check_eq("rst_edge", bus_a.sweep_edge, 1'b1);
        check_eq("rst_cmds", {bus_a.update, bus_a.update_config, bus_a.sweep}, 3'b000);
        check_eq("rst_errs", {bus_a.err_param, bus_a.err_timeout, bus_a.done}, 3'b000);
        check_eq("rst_lower", bus_a.lower_limit, 32'd0);
        check_eq("rst_sweeps", bus_a.sweeps_done, 16'd0);
        rst = 1'b1;
        @(negedge clk);

        // Two bidirectional sweeps with dwell 4.
        plan_a(32'd1105322465, 32'd1421128884, 32'd12632, 16'd2, 24'd4, 1'b1);
        log_a.delete(); d0 = done_a;
        start_a();
        t1 = -1; t2 = -1; n = 0;
        while (bus_a.busy && n < 3000) begin
            @(negedge clk); n++;
            if (t1 < 0 && bus_a.sweeps_done == 16'd1) t1 = cyc;
            if (t1 >= 0 && t2 < 0 && bus_a.update_config) t2 = cyc;
        end
        check_eq("t1_idle_to", bus_a.busy, 1'b0);
        @(negedge clk);
        check_log("t1_log", log_a, '{1, 11, 3, 10, 3, 10});
        check_eq("t1_sweeps", bus_a.sweeps_done, 16'd2);
        check_eq("t1_done", done_a - d0, 1);
        check_eq("t1_dwell_lat", t2 - t1, 5);
        check_eq("t1_lower", bus_a.lower_limit, 32'd1105322465);
        check_eq("t1_upper", bus_a.upper_limit, 32'd1421128884);
        check_eq("t1_nstep", bus_a.negitive_step, 32'd12632);
        check_eq("t1_nrate", bus_a.negitive_rate, 16'd1);

        // Invalid plan: lower == upper.
        plan_a(32'd1000, 32'd1000, 32'd5, 16'd1, 24'd0, 1'b0);
        log_a.delete();
        start_a();
        busy_or = 0;
        repeat (10) begin @(negedge clk); busy_or |= int'(bus_a.busy); end
        check_eq("t2_err_param", bus_a.err_param, 1'b1);
        check_eq("t2_busy", busy_or, 0);
        check_eq("t2_cmds", log_a.size(), 0);

        // Endless run, abort in DWELL after three sweeps.
        plan_a(32'd10, 32'd20, 32'd1, 16'd0, 24'd40, 1'b0);
        log_a.delete(); d0 = done_a;
        start_a();
        check_eq("t3_err_clr", bus_a.err_param, 1'b0);
        n = 0;
        while (bus_a.sweeps_done != 16'd3 && n < 2000) begin @(negedge clk); n++; end
        check_eq("t3_reach3", bus_a.sweeps_done, 16'd3);
        repeat (5) @(negedge clk);
        abort_a();
        wait_idle_a(100, "t3");
        check_log("t3_log", log_a, '{1, 11, 3, 11, 3, 11, 3, 11});
        check_eq("t3_sweeps", bus_a.sweeps_done, 16'd3);
        check_eq("t3_no_done", done_a - d0, 0);

        // Abort while waiting for update ack.
        plan_a(32'd10, 32'd20, 32'd1, 16'd2, 24'd0, 1'b0);
        log_a.delete(); d0 = done_a;
        start_a();
        n = 0;
        while (!bus_a.update && n < 20) begin @(negedge clk); n++; end
        check_eq("t5_upd_seen", bus_a.update, 1'b1);
        bus_a.abort = 1'b1;
        @(negedge clk) bus_a.abort = 1'b0;
        wait_idle_a(100, "t5");
        repeat (5) @(negedge clk);
        check_log("t5_log", log_a, '{1, 11});
        check_eq("t5_no_done", done_a - d0, 0);

        // Reset during RUN, then a normal single sweep.
        plan_a(32'd10, 32'd20, 32'd1, 16'd0, 24'd4, 1'b1);
        start_a();
        n = 0;
        while (!bus_a.sweep && n < 50) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        check_eq("t6_in_run", bus_a.busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_busy", bus_a.busy, 1'b0);
        check_eq("t6_rst_lower", bus_a.lower_limit, 32'd0);
        check_eq("t6_rst_edge", bus_a.sweep_edge, 1'b1);
        @(negedge clk) rst = 1'b1;
        plan_a(32'd10, 32'd20, 32'd1, 16'd1, 24'd0, 1'b1);
        log_a.delete(); d0 = done_a;
        start_a();
        wait_idle_a(1000, "t6");
        check_log("t6_log", log_a, '{1, 11, 3, 11});
        check_eq("t6_sweeps", bus_a.sweeps_done, 16'd1);
        check_eq("t6_done", done_a - d0, 1);

        // Timeout in RUN on the 50-cycle instance.
        log_b.delete();
        @(negedge clk) bus_b.start = 1'b1;
        @(negedge clk) bus_b.start = 1'b0;
        n = 0;
        while (!bus_b.sweep && n < 50) begin @(negedge clk); n++; end
        t1 = cyc;
        n = 0;
        while (!bus_b.err_timeout && n < 200) begin @(negedge clk); n++; end
        t2 = cyc;
        check_eq("t4_err_timeout", bus_b.err_timeout, 1'b1);
        check_eq("t4_latency", t2 - t1, 54);
        check_eq("t4_busy", bus_b.busy, 1'b0);
        repeat (20) @(negedge clk);
        check_log("t4_log", log_b, '{1, 11, 3});

        check_eq("proto_a", a_proto, 0);
        check_eq("proto_b", b_proto, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
